// File: rtl/cla_subtractor_pipe.sv
`default_nettype none
// ============================================================================
// Module  : cla_subtractor_pipe
// Brief   : Pipelined, segmented carry-lookahead subtractor.
//           d = a - b - bin (mod 2^WIDTH), bout = borrow-out.
//           Computed as a + ~b + ~bin; one lookahead segment per stage, with
//           the inter-segment carry registered at each stage boundary.
//           Valid/ready on both sides with a single global advance enable.
//           Optional signed-overflow output when SUB_OVF_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module cla_subtractor_pipe #(
    parameter int WIDTH = 32,
    parameter int SEGS  = 4     // must divide WIDTH; latency is SEGS cycles
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
`ifdef SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int c_SEG_W = WIDTH / SEGS;

    logic            r_rdy;     // low in reset, high from the first edge after release
    logic [SEGS-1:0] r_v;       // per-stage valid bits
    logic [SEGS-1:0] w_cy;      // registered carry-out of each segment
    logic            w_adv;     // global advance: every stage moves together
    logic            w_push;    // input beat accepted this cycle

    assign w_adv     = ~r_v[SEGS-1] | out_ready;
    assign in_ready  = w_adv & r_rdy;
    assign w_push    = in_valid & in_ready;
    assign out_valid = r_v[SEGS-1];
    // Carry registers reset to 1 so that bout reads 0 while in reset.
    assign bout      = ~w_cy[SEGS-1];

    // Hold off input acceptance until one edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rdy <= 1'b0;
        else        r_rdy <= 1'b1;
    end

    // Valid bits shift with the advance enable; a bubble enters when nothing is pushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
        end else if (w_adv) begin
            r_v[0] <= w_push;
            for (int k = 1; k < SEGS; k++) begin
                r_v[k] <= r_v[k-1];
            end
        end
    end

    generate
        for (genvar j = 0; j < SEGS; j++) begin : g_seg
            // Result slice j is produced in stage j and held through stage SEGS-1.
            localparam int c_DEPTH = SEGS - j;

            logic [c_SEG_W-1:0] w_x;      // minuend slice
            logic [c_SEG_W-1:0] w_y;      // inverted subtrahend slice
            logic               w_cin;
            logic [c_SEG_W-1:0] w_p;
            logic [c_SEG_W-1:0] w_g;
            logic [c_SEG_W-1:0] w_c;      // carry into each bit
            logic               w_gp;
            logic               w_gg;
            logic               w_cout;
            logic [c_SEG_W-1:0] w_sum;
            logic               w_en;     // load enable for this segment's stage
            logic               r_cout;
            logic [c_SEG_W-1:0] r_s [c_DEPTH];

            assign w_en = (j == 0) ? w_push : w_adv;

            if (j == 0) begin : g_first
                assign w_x   = a[c_SEG_W-1:0];
                assign w_y   = ~b[c_SEG_W-1:0];
                assign w_cin = ~bin;
            end else begin : g_skew
                // Operand slices ride a j-deep skew line so they meet their carry in stage j
                logic [c_SEG_W-1:0] r_xa [j];
                logic [c_SEG_W-1:0] r_xb [j];

                // Operand skew line: sampled on accept, then shifted on advance
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int i = 0; i < j; i++) begin
                            r_xa[i] <= '0;
                            r_xb[i] <= '0;
                        end
                    end else begin
                        if (w_push) begin
                            r_xa[0] <= a[j*c_SEG_W +: c_SEG_W];
                            r_xb[0] <= ~b[j*c_SEG_W +: c_SEG_W];
                        end
                        if (w_adv) begin
                            for (int i = 1; i < j; i++) begin
                                r_xa[i] <= r_xa[i-1];
                                r_xb[i] <= r_xb[i-1];
                            end
                        end
                    end
                end

                assign w_x   = r_xa[j-1];
                assign w_y   = r_xb[j-1];
                assign w_cin = w_cy[j-1];
            end

            // Lookahead segment: each bit carry from the prefix group P/G and carry-in
            always_comb begin
                w_p  = w_x | w_y;
                w_g  = w_x & w_y;
                w_c  = '0;
                w_gg = 1'b0;
                w_gp = 1'b1;
                for (int i = 0; i < c_SEG_W; i++) begin
                    w_c[i] = w_gg | (w_gp & w_cin);
                    w_gg   = w_g[i] | (w_p[i] & w_gg);
                    w_gp   = w_gp & w_p[i];
                end
                w_sum  = w_x ^ w_y ^ w_c;
                w_cout = w_gg | (w_gp & w_cin);
            end

            // Stage-boundary carry register and result skew line for this slice
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cout <= 1'b1;
                    for (int i = 0; i < c_DEPTH; i++) begin
                        r_s[i] <= '0;
                    end
                end else begin
                    if (w_en) begin
                        r_cout <= w_cout;
                        r_s[0] <= w_sum;
                    end
                    if (w_adv) begin
                        for (int i = 1; i < c_DEPTH; i++) begin
                            r_s[i] <= r_s[i-1];
                        end
                    end
                end
            end

            assign w_cy[j]                   = r_cout;
            assign d[j*c_SEG_W +: c_SEG_W]   = r_s[c_DEPTH-1];

`ifdef SUB_OVF_EN
            if (j == SEGS - 1) begin : g_ovf
                logic r_ovf;
                logic w_ovf;

                // Operand signs differ and the result sign differs from the minuend.
                // w_y holds ~b, so a and b signs differ when x and y MSBs match.
                assign w_ovf = ~(w_x[c_SEG_W-1] ^ w_y[c_SEG_W-1]) &
                               (w_sum[c_SEG_W-1] ^ w_x[c_SEG_W-1]);

                // Overflow flag registered in the final stage, aligned with d
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)    r_ovf <= 1'b0;
                    else if (w_en) r_ovf <= w_ovf;
                end

                assign ovf = r_ovf;
            end
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cla_subtractor_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_cla_subtractor_pipe
// Brief   : Self-checking bench for cla_subtractor_pipe (WIDTH=32, SEGS=4).
//           Inputs change on the falling edge; outputs are sampled 1ns later.
//           Expected results come from plain wide-integer subtraction.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cla_subtractor_pipe;

    localparam int WIDTH = 32;
    localparam int SEGS  = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             bin       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [WIDTH+1:0] expq[$];   // {ovf, bout, d}

    cla_subtractor_pipe #(.WIDTH(WIDTH), .SEGS(SEGS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
`ifdef SUB_OVF_EN
        .ovf       (ovf),
`endif
        .bout      (bout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: unsigned (WIDTH+1)-bit subtraction gives {borrow, difference}
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                               input logic [WIDTH-1:0] mb,
                                               input logic mbin);
        logic [WIDTH:0] diff;
        logic o;
        diff = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mbin};
        o = 1'b0;
`ifdef SUB_OVF_EN
        o = (ma[WIDTH-1] != mb[WIDTH-1]) && (diff[WIDTH-1] != ma[WIDTH-1]);
`endif
        return {o, diff};
    endfunction

    function automatic logic [WIDTH+1:0] obs();
        logic o;
        o = 1'b0;
`ifdef SUB_OVF_EN
        o = ovf;
`endif
        return {o, bout, d};
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return WIDTH'(1);
            default: return $urandom();
        endcase
    endfunction

    // Drive one cycle's inputs on the falling edge, then let combinational outputs settle
    task automatic step(input logic iv, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vbin, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        a         = va;
        b         = vb;
        bin       = vbin;
        out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        checks++; if (obs() !== '0) begin errors++; $display("FAIL rst_outputs got %h want 0", obs()); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_early got %b want 0", in_ready); end
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise got %b want 1", in_ready); end
    endtask

    task automatic test_latency();
        int  n;
        bit  seen;
        step(1'b1, 32'd5, 32'd3, 1'b0, 1'b1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_accept got %b want 1", in_ready); end
        n = cyc;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            if (out_valid === 1'b1) begin
                seen = 1;
                checks++; if (cyc - n != SEGS) begin errors++; $display("FAIL lat_cycles got %0d want %0d", cyc - n, SEGS); end
                checks++; if (obs() !== {2'b00, 32'h0000_0002}) begin errors++; $display("FAIL lat_data got %h want %h", obs(), {2'b00, 32'h2}); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL lat_timeout got no out_valid want out_valid"); end
    endtask

    task automatic test_borrow();
        expq.delete();
        step(1'b1, 32'h0, 32'h1, 1'b0, 1'b1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL brw_accept0 got %b want 1", in_ready); end
        expq.push_back({2'b01, 32'hFFFF_FFFF});
        step(1'b1, 32'h0, 32'h0, 1'b1, 1'b1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL brw_accept1 got %b want 1", in_ready); end
        expq.push_back({2'b01, 32'hFFFF_FFFF});
        for (int k = 0; k < 20 && expq.size() > 0; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            if (out_valid && out_ready) begin
                checks++; if (obs() !== expq[0]) begin errors++; $display("FAIL brw_data got %h want %h", obs(), expq[0]); end
                void'(expq.pop_front());
            end
        end
        checks++; if (expq.size() != 0) begin errors++; $display("FAIL brw_timeout got %0d pending want 0", expq.size()); end
    endtask

`ifdef SUB_OVF_EN
    task automatic test_ovf();
        expq.delete();
        step(1'b1, 32'h8000_0000, 32'h1, 1'b0, 1'b1);
        expq.push_back({2'b10, 32'h7FFF_FFFF});
        step(1'b1, 32'h3, 32'h2, 1'b0, 1'b1);
        expq.push_back({2'b00, 32'h1});
        for (int k = 0; k < 20 && expq.size() > 0; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            if (out_valid && out_ready) begin
                checks++; if (obs() !== expq[0]) begin errors++; $display("FAIL ovf_data got %h want %h", obs(), expq[0]); end
                void'(expq.pop_front());
            end
        end
        checks++; if (expq.size() != 0) begin errors++; $display("FAIL ovf_timeout got %0d pending want 0", expq.size()); end
    endtask
`endif

    task automatic test_back_to_back();
        int sent = 0;
        int got  = 0;
        bit have_held = 0;
        logic ordy;
        logic [WIDTH+1:0] held;
        for (int t = 0; t < 40 && got < 8; t++) begin
            ordy = !(t >= 6 && t < 9);
            step(sent < 8, WIDTH'(100 + sent), WIDTH'(sent), sent[0], ordy);
            if (!ordy && out_valid) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready got %b want 0", in_ready); end
                if (!have_held) begin
                    held = obs();
                    have_held = 1;
                end else begin
                    checks++; if (obs() !== held) begin errors++; $display("FAIL b2b_hold got %h want %h", obs(), held); end
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                checks++;
                if (obs() !== {2'b00, WIDTH'(100 - (got & 1))}) begin
                    errors++; $display("FAIL b2b_data got %h want %h", obs(), {2'b00, WIDTH'(100 - (got & 1))});
                end
                got++;
            end
        end
        checks++; if (got != 8 || sent != 8) begin errors++; $display("FAIL b2b_count got %0d/%0d want 8/8", sent, got); end
        checks++; if (!have_held) begin errors++; $display("FAIL b2b_no_stall got no held beat want held beat"); end
        for (int k = 0; k < 6; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra got %b want 0", out_valid); end
        end
    endtask

    task automatic test_random();
        bit stalled = 0;
        logic [WIDTH+1:0] prev = '0;
        expq.delete();
        for (int t = 0; t < 400; t++) begin
            step($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || obs() !== prev) begin
                    errors++; $display("FAIL rnd_hold got %b/%h want 1/%h", out_valid, obs(), prev);
                end
            end
            stalled = out_valid && !out_ready;
            prev = obs();
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious got %h want no beat", obs());
                end else begin
                    if (obs() !== expq[0]) begin errors++; $display("FAIL rnd_data got %h want %h", obs(), expq[0]); end
                    void'(expq.pop_front());
                end
            end
            if (in_valid && in_ready) expq.push_back(model(a, b, bin));
        end
        for (int k = 0; k < 40 && expq.size() > 0; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            if (out_valid && out_ready) begin
                checks++; if (obs() !== expq[0]) begin errors++; $display("FAIL rnd_drain got %h want %h", obs(), expq[0]); end
                void'(expq.pop_front());
            end
        end
        checks++; if (expq.size() != 0) begin errors++; $display("FAIL rnd_lost got %0d pending want 0", expq.size()); end
    endtask

    task automatic test_reset_mid();
        int  acc = 0;
        int  outs = 0;
        bit  seen = 0;
        for (int k = 0; k < 10 && acc < 3; k++) begin
            step(1'b1, WIDTH'(k + 1), '0, 1'b0, 1'b0);
            if (in_valid && in_ready) acc++;
        end
        for (int k = 0; k < 10 && !seen; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0);
            seen = (out_valid === 1'b1);
        end
        checks++; if (!seen) begin errors++; $display("FAIL rmid_pre got no out_valid want out_valid"); end
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_async got %b want 0", out_valid); end
        checks++; if (obs() !== '0) begin errors++; $display("FAIL rmid_outputs got %h want 0", obs()); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale got %b want 0", out_valid); end
        end
        acc = 0;
        for (int k = 0; k < 10 && acc == 0; k++) begin
            step(1'b1, 32'd7, 32'd7, 1'b0, 1'b1);
            if (in_valid && in_ready) acc++;
        end
        checks++; if (acc != 1) begin errors++; $display("FAIL rmid_accept got %0d want 1", acc); end
        for (int k = 0; k < 12; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            if (out_valid && out_ready) begin
                outs++;
                checks++; if (obs() !== '0) begin errors++; $display("FAIL rmid_data got %h want 0", obs()); end
            end
        end
        checks++; if (outs != 1) begin errors++; $display("FAIL rmid_count got %0d want 1", outs); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_borrow();
`ifdef SUB_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/cla_subtractor_pipe.md
Name: cla_subtractor_pipe

Overview:
- Pipelined, segmented carry-lookahead subtractor computing d = a - b - bin (mod 2^WIDTH) with borrow-out.
- Companion to the combinational lookahead adder: same group propagate/generate math (a + ~b + ~bin), but pipelined for timing closure in datapaths that need subtraction at high clock rates.
- Sits between a valid/ready producer and a valid/ready consumer.
- Supports full-throughput streaming and backpressure.

Parameters:
- WIDTH, 32: operand/result width in bits.
- SEGS, 4: number of pipeline segments. Must divide WIDTH evenly. Each segment handles WIDTH/SEGS bits. Latency is SEGS cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  minuend, unsigned
- b  input  WIDTH  subtrahend, unsigned
- bin  input  1  borrow-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- d  output  WIDTH  difference
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned)
- ovf  output  1  signed overflow; present only with SUB_OVF_EN

Behaviour:
- Reset: clk and rst_n are the only clock/reset. Reset is asynchronous, active-low. While rst_n=0:
  - all stage valid bits clear; out_valid=0.
  - d, bout and ovf read 0.
  - in_ready=0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- Arithmetic: internally computes a + ~b + carry_in, where carry_in = ~bin. Then bout = ~carry_out of the top segment.
- Segment k (k=0..SEGS-1), for bit slice [k*W/S +: W/S]:
  - built as a lookahead block with per-bit p = x|y, g = x&y;
  - produces group P/G;
  - carry into segment k = carry out of segment k-1, registered at the stage boundary (borrow chain crosses one register per segment).
- Skew registers:
  - Upper operand slices are delayed so segment k sees its slice in stage k.
  - Lower result slices are delayed so all of d emerges aligned in the final stage.
- Latency: a beat accepted on cycle N produces out_valid=1 on cycle N+SEGS, provided there is no stall.
- Handshake:
  - Transfer on the input occurs when in_valid & in_ready; on the output when out_valid & out_ready.
  - Global advance enable: adv = ~out_valid | out_ready.
  - in_ready = adv (after reset release).
  - When adv=0, every stage register, including valid bits and skew registers, holds.
  - Beats are never dropped, duplicated or reordered.
  - a, b and bin are sampled only on an accepted beat.
- Bubbles: if in_valid=0 when adv=1, a bubble (valid=0) enters stage 0. Data registers of invalid stages may hold any value; d/bout are don't-care while out_valid=0 but must be stable while out_valid=1 and out_ready=0.
- Simultaneous events: a pop and a push in the same cycle are both allowed, giving full throughput of one beat per cycle.
- Reset mid-operation: all in-flight beats are discarded immediately and asynchronously. No stale beat appears after release.
- SEGS=1: a single registered stage with latency 1. The same handshake rules apply.

Optional Feature:
- Macro: SUB_OVF_EN.
- Defined:
  - ovf port exists.
  - ovf = (a[W-1] != b[W-1]) & (d[W-1] != a[W-1]), pipelined and aligned with d.
  - ovf resets to 0.
- Undefined: no ovf port and no related logic. Otherwise identical.

Test Plan (WIDTH=32, SEGS=4):
- After rst_n release, a=5, b=3, bin=0, out_ready=1 -> out_valid exactly 4 cycles after acceptance; d=0x00000002, bout=0.
- a=0, b=1, bin=0 -> d=0xFFFFFFFF, bout=1, exercising a borrow that propagates through all 4 segment registers. Also a=0, b=0, bin=1 -> d=0xFFFFFFFF, bout=1.
- SUB_OVF_EN defined, a=0x80000000, b=1, bin=0 -> d=0x7FFFFFFF, bout=0, ovf=1. Then a=0x00000003, b=0x00000002 -> ovf=0.
- Stream 8 back-to-back beats (a=100+i, b=i, bin=i&1) with out_ready low for 3 cycles mid-stream:
  - in_ready=0 during the stall;
  - outputs d=100-(i&1) are in order;
  - no loss or duplication;
  - held outputs are stable during the stall.
- Accept 3 beats, then pulse rst_n low mid-cycle:
  - out_valid=0 asynchronously;
  - after release, no output appears until a new beat is accepted;
  - the new beat a=7, b=7, bin=0 -> d=0, bout=0.
